// File: rtl/sync_fifo_pack.sv
// Packing synchronous FIFO. RATIO narrow writes are assembled little-endian
// into one wide word, and that word is pushed into a DEPTH-entry store.
// Reads return whole words on a registered output. Only complete words
// count toward the occupancy flags.
module sync_fifo_pack #(
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned RATIO     = 4,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         wn,
    input  logic                         rn,
    input  logic [IN_WIDTH-1:0]          DATAIN,
    output logic [IN_WIDTH*RATIO-1:0]    DATAOUT,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned OW = IN_WIDTH * RATIO;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned LW = $clog2(RATIO);

    logic [OW-1:0] mem_q [DEPTH];
    logic [OW-1:0] pack_q;
    logic [OW-1:0] word_d;
    logic [OW-1:0] dout_q;
    logic [LW-1:0] lane_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          ovf_q;
    logic          unf_q;
    logic          wr_acc;
    logic          rd_acc;
    logic          lane_last;
    logic          push;

    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= CW'(DEPTH - AF_THRESH));

    assign wr_acc    = wn & ~full;
    assign rd_acc    = rn & ~empty;
    assign lane_last = (lane_q == LW'(RATIO - 1));
    assign push      = wr_acc & lane_last;

    assign DATAOUT   = dout_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

    // Merge the incoming lane into the packing register to form the next word.
    always_comb begin
        word_d = pack_q;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (lane_q == LW'(i)) begin
                word_d[i*IN_WIDTH +: IN_WIDTH] = DATAIN;
            end
        end
    end

    // Occupancy only moves on a push or a pop alone; both together cancel.
    always_comb begin
        count_d = count_q;
        case ({push, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Word storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= word_d;
        end
    end

    // Pointers, lane, packing register, output register and sticky flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pack_q   <= '0;
            lane_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (wr_acc) begin
                pack_q <= word_d;
                lane_q <= lane_last ? '0 : lane_q + 1'b1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                dout_q   <= mem_q[rd_ptr_q];
            end
            count_q <= count_d;
            if (wn && full) begin
                ovf_q <= 1'b1;
            end
            if (rn && empty) begin
                unf_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_pack.sv
// Self-checking bench for sync_fifo_pack: stimulus pushes expected read words
// into a scoreboard queue, and an independent monitor pops and compares them
// whenever the DUT accepts a read.
module tb_sync_fifo_pack;

    localparam int unsigned DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wn    = 1'b0;
    logic        rn    = 1'b0;
    logic [7:0]  DATAIN = '0;
    logic [31:0] DATAOUT;
    logic        full, empty, almost_full, overflow, underflow;
    logic [4:0]  count;

    int total = 0;
    int bad   = 0;

    // Bench-side reference state
    logic [31:0] exp_q[$];
    logic [31:0] m_q[$];
    logic [31:0] m_pack;
    int          m_lane;
    logic        m_ovf, m_unf;

    sync_fifo_pack #(.IN_WIDTH(8), .RATIO(4), .DEPTH(DEPTH), .AF_THRESH(2)) dut (
        .clock(clock), .reset(reset), .wn(wn), .rn(rn), .DATAIN(DATAIN),
        .DATAOUT(DATAOUT), .full(full), .empty(empty), .almost_full(almost_full),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_pack = '0;
        m_lane = 0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    // One clock of stimulus; model updated from pre-edge state.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        bit pre_full, pre_empty;
        pre_full  = (m_q.size() == DEPTH);
        pre_empty = (m_q.size() == 0);
        if (r) begin
            if (pre_empty) m_unf = 1'b1;
            else           exp_q.push_back(m_q.pop_front());
        end
        if (w) begin
            if (pre_full) m_ovf = 1'b1;
            else begin
                m_pack[m_lane*8 +: 8] = d;
                if (m_lane == 3) begin
                    m_q.push_back(m_pack);
                    m_lane = 0;
                end else m_lane++;
            end
        end
        wn = w; rn = r; DATAIN = d;
        @(posedge clock);
        #1;
        wn = 1'b0; rn = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        cyc(1'b1, 1'b0, d);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"},  32'(full), 32'd0);
        chk({tag, "_af"},    32'(almost_full), 32'd0);
        chk({tag, "_ovf"},   32'(overflow), 32'd0);
        chk({tag, "_unf"},   32'(underflow), 32'd0);
        chk({tag, "_dout"},  DATAOUT, 32'd0);
    endtask

    // Mid-cycle 3 ns reset pulse, checked while asserted.
    task automatic rst_pulse(input string tag);
        #1 reset = 1'b1;
        model_clear();
        #1 check_reset_vals(tag);
        #2 reset = 1'b0;
    endtask

    // Monitor: a read accepted at an edge presents its word 1 ns later.
    initial begin
        forever begin
            @(posedge clock);
            if (!reset && rn && !empty) begin
                #1;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_extra_read: got %h want no read", DATAOUT);
                end else begin
                    chk("sb_dataout", DATAOUT, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        model_clear();
        #2 check_reset_vals("por");
        #5 reset = 1'b0;

        // Partial word then read from empty: ignored, underflow set
        wr(8'h01); wr(8'h02); wr(8'h03);
        chk("partial_empty", 32'(empty), 32'd1);
        chk("partial_count", 32'(count), 32'd0);
        cyc(1'b0, 1'b1, 8'h00);
        chk("unf_set",   32'(underflow), 32'd1);
        chk("unf_dout",  DATAOUT, 32'd0);
        chk("unf_empty", 32'(empty), 32'd1);
        rst_pulse("rst1");

        // Basic packing
        wr(8'h11); wr(8'h22); wr(8'h33);
        chk("b3_count", 32'(count), 32'd0);
        wr(8'h44);
        chk("b4_count", 32'(count), 32'd1);
        chk("b4_empty", 32'(empty), 32'd0);
        cyc(1'b0, 1'b1, 8'h00);
        chk("b_dout", DATAOUT, 32'h44332211);
        chk("b_empty", 32'(empty), 32'd1);

        // Fill to 16 words; pointers start at 1 so they wrap
        for (int k = 0; k < 64; k++) begin
            wr(8'(k) ^ 8'h5A);
            if (k % 4 == 3) begin
                chk("fill_count", 32'(count), 32'((k + 1) / 4));
                chk("fill_af", 32'(almost_full), 32'(((k + 1) / 4) >= 14));
            end
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("pre_ovf", 32'(overflow), 32'd0);
        wr(8'hEE);
        chk("ovf_set",   32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);

        // Write+read while full: read taken, write dropped
        cyc(1'b1, 1'b1, 8'hEF);
        chk("wr_rd_full_count", 32'(count), 32'd15);
        chk("wr_rd_full_ovf",   32'(overflow), 32'd1);
        chk("wr_rd_full_full",  32'(full), 32'd0);
        for (int k = 0; k < 15; k++) cyc(1'b0, 1'b1, 8'h00);
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_af", 32'(almost_full), 32'd0);

        // Steady state: count 5, one read per word written
        for (int k = 0; k < 20; k++) wr(8'(100 + k));
        chk("ss_count0", 32'(count), 32'd5);
        for (int g = 0; g < 3; g++) begin
            wr(8'(16 * g + 1)); wr(8'(16 * g + 2)); wr(8'(16 * g + 3));
            cyc(1'b1, 1'b1, 8'(16 * g + 4));
            chk("ss_count", 32'(count), 32'd5);
        end
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 8'h00);
        chk("ss_empty", 32'(empty), 32'd1);

        // Reset mid-word discards partial lanes
        wr(8'h01); wr(8'h02);
        rst_pulse("rst2");
        wr(8'hAA); wr(8'hBB); wr(8'hCC); wr(8'hDD);
        chk("post_rst_count", 32'(count), 32'd1);
        cyc(1'b0, 1'b1, 8'h00);
        chk("post_rst_dout", DATAOUT, 32'hDDCCBBAA);

        @(posedge clock); #2;
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
